cvxif_pau_q: RTL and testbench
==============================

# cvxif_pau_q

Parametrised posit arithmetic coprocessor on the CORE-V-X-IF (CV-X-IF) offload interface. It is the next generation of the single-operation PAU: posit width and exponent size, execution latency and result buffering are parameters. It adds instruction-ID tracking, SUB/MIN/MAX operations, a register-ready handshake and a result FIFO. The core can therefore issue the next posit instruction before it drains earlier results. It sits beside the core's X-interface, next to the existing posit_add/posit_mult/posit_div units.

## Interface
- N, 16, posit width in bits (8..32).
- ES, 1, posit exponent size.
- LATENCY, 3, minimum EXEC cycles before the unit result is sampled (>=1).
- DEPTH, 2, result FIFO depth (power of two, >=2).
- ID_W, 4, instruction ID width.
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- issue_valid  in  1  issue request valid.
- issue_ready  out  1  coprocessor can take an issue request.
- issue_req_instr  in  32  offloaded instruction word.
- issue_req_id  in  ID_W  ID of the offloaded instruction.
- issue_resp_accept  out  1  instruction accepted; valid only on an issue handshake.
- issue_resp_writeback  out  1  result will be written to rd; equals issue_resp_accept.
- issue_resp_register_read  out  2  source registers needed; 2'b11 when accepted, else 2'b00.
- register_valid  in  1  operand transfer valid.
- register_ready  out  1  coprocessor waiting for operands.
- register_id  in  ID_W  ID of the operand transfer.
- register_rs0, register_rs1  in  32  operands; posit taken from bits [N-1:0].
- register_rs_valid  in  2  per-operand valid bits.
- result_valid  out  1  FIFO head valid.
- result_ready  in  1  core takes result.
- result_data  out  32  posit result, zero-extended from N bits.
- result_id  out  ID_W  ID of the head result.
- result_rd  out  5  destination register of the head result.

## Operation
- Match rule: opcode [6:0]=7'b1111011, funct7 [31:25]=7'b0000000, funct3 [14:12] in {000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MIN, 101 MAX}. Any other funct3 or encoding is rejected.
- FSM has three states: IDLE, WAIT_REG, EXEC.
- IDLE:
  - issue_ready = (fifo_count < DEPTH).
  - On issue_valid && issue_ready && match: accept. Latch funct3, issue_req_id and rd ([11:7]), then go to WAIT_REG.
  - On a non-match handshake: accept=0, writeback=0, register_read=00, stay in IDLE.
- WAIT_REG:
  - register_ready=1.
  - Operands are captured on register_valid && register_rs_valid==2'b11 && register_id==latched id. Next state is EXEC with the counter cleared.
  - A transfer whose id mismatches is ignored; the block stays in WAIT_REG.
- EXEC:
  - start=1 to all units.
  - The counter increments until it equals LATENCY.
  - When counter==LATENCY and the selected done is high, push {result, id, rd} to the FIFO and return to IDLE.
  - If done is low at that point, the block remains in EXEC.
- Operation semantics:
  - SUB feeds the adder with b two's-complement negated (NaR and zero map to themselves).
  - MIN and MAX compare the posits as N-bit signed integers, need no unit, and are "done" immediately. NaR is therefore the minimum.
  - DIV by zero yields NaR (1 followed by N-1 zeros), as produced by posit_div.
- At most one instruction is in WAIT_REG/EXEC at a time. Because accept requires fifo_count<DEPTH and nothing else pushes, the push never overflows.
- FIFO behaviour:
  - Pop occurs on result_valid && result_ready.
  - On a simultaneous push and pop, the count is unchanged.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values: issue_ready=0 during the reset cycle, then 1; all other outputs 0, FIFO empty, state IDLE.
- Issue handshake happens in cycle t0 and WAIT_REG starts at t0+1. register_ready rises at t0+1.
- Operand handshake happens in cycle t1. EXEC runs cycles t1+1..t1+1+LATENCY. The push occurs at the end of t1+1+LATENCY.
- With an empty FIFO, result_valid is asserted in cycle t1+2+LATENCY. The end-to-end minimum latency is therefore LATENCY+3 cycles from issue.
- issue_ready may rise in the cycle after the push (IDLE), while earlier results are still unread.
- result_valid, result_data, result_id and result_rd are held stable until popped.
- The issue_resp_* outputs are combinational in the handshake cycle.
- rst mid-operation (any state, FIFO non-empty) discards the in-flight op and all buffered results. The next cycle follows the reset values above.

## Test plan
- ADD: issue id=3 rd=5 with 0x4000+0x5000, result_ready=1. Expect result_data=0x00005800, result_id=3, result_rd=5, at LATENCY+3 cycles after issue.
- SUB/MUL/DIV: 0x5000-0x4000 gives 0x4000; 0x5000*0x5000 gives 0x6000; 0x4000/0x5000 gives 0x3000; 0x4000/0x0000 gives 0x8000 (NaR).
- MIN/MAX: MIN(0x5000, 0xB000) gives 0xB000; MAX gives 0x5000; MIN(0x8000, 0x4000) gives 0x8000.
- Backpressure: result_ready=0, issue DEPTH ADDs. issue_ready goes low once the FIFO is full. Releasing result_ready returns results in order with correct IDs, and issue_ready rises again.
- Reject and mismatch:
  - funct3=110 gives accept=0, register_read=00, and no register_ready.
  - A register transfer with a wrong register_id is ignored. The correct id then completes normally.
- Reset: assert rst during EXEC with one buffered result. Expect result_valid=0 and the FIFO empty afterward; a new ADD completes normally.

Source files
------------

// File: rtl/cvxif_pau_q.sv
// Posit arithmetic coprocessor on the CV-X-IF offload interface.
// One instruction in flight, with buffered results tagged by instruction ID and rd.
module cvxif_pau_q #(
    parameter int N       = 16,
    parameter int ES      = 1,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 2,
    parameter int ID_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [31:0]     issue_req_instr,
    input  logic [ID_W-1:0] issue_req_id,
    output logic            issue_resp_accept,
    output logic            issue_resp_writeback,
    output logic [1:0]      issue_resp_register_read,
    input  logic            register_valid,
    output logic            register_ready,
    input  logic [ID_W-1:0] register_id,
    input  logic [31:0]     register_rs0,
    input  logic [31:0]     register_rs1,
    input  logic [1:0]      register_rs_valid,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [31:0]     result_data,
    output logic [ID_W-1:0] result_id,
    output logic [4:0]      result_rd
);

    localparam int FW = N;
    localparam int WW = 2 * FW + 4;
    localparam int EW = FW + 5;
    localparam int SW = N + 1 + ES + FW;
    localparam int CW = $clog2(LATENCY + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT_REG, S_EXEC} state_e;

    // Unpack a nonzero, non-NaR posit into sign, scale and 1.f significand.
    function automatic void pdec(input logic [N-1:0] p, output logic s, output int sc,
                                 output logic [FW:0] m);
        logic [N-1:0] pa;
        logic [N-2:0] body, x, rem, frac;
        int run;
        s    = p[N-1];
        pa   = s ? -p : p;
        body = pa[N-2:0];
        x    = body[N-2] ? ~body : body;
        run  = N - 1;
        for (int i = 0; i < N - 1; i++) if (x[i]) run = N - 2 - i;
        sc   = (body[N-2] ? run - 1 : -run) * (1 << ES);
        rem  = body << (run + 1);
        sc   = sc + int'(rem >> (N - 1 - ES));
        frac = rem << ES;
        m    = {1'b1, frac, 1'b0};
    endfunction

    // Build regime/exponent/fraction, then round to nearest even; never rounds to zero or NaR.
    function automatic logic [N-1:0] penc(input logic s, input int sc, input logic [FW-1:0] f,
                                          input logic stk);
        int k, e, run;
        logic r, g, st;
        logic [SW-1:0] sv, t;
        logic [N-2:0] body;
        logic [N-1:0] mag;
        k = sc >>> ES;
        e = sc - k * (1 << ES);
        if (k > N - 2) begin
            mag = {1'b0, {(N-1){1'b1}}};
        end else if (k < -(N - 2)) begin
            mag = {{(N-1){1'b0}}, 1'b1};
        end else begin
            r    = (k >= 0);
            run  = r ? k + 1 : -k;
            sv   = {{N{r}}, ~r, {(ES+FW){1'b0}}} | (SW'(e) << FW) | SW'(f);
            t    = sv << (N - run);
            body = t[SW-1 -: N-1];
            g    = t[SW-N];
            st   = stk | (|t[SW-N-1:0]);
            mag  = {1'b0, body} + N'(g & (st | body[0]));
        end
        return s ? -mag : mag;
    endfunction

    function automatic logic [N-1:0] pnorm(input logic s, input int sc, input logic [WW-1:0] v,
                                           input int hp, input logic stk);
        int p;
        logic [WW-1:0] vn;
        p = 0;
        for (int i = 0; i < WW; i++) if (v[i]) p = i;
        vn = v << (WW - 1 - p);
        return penc(s, sc + p - hp, vn[WW-2 -: FW], stk | (|vn[WW-2-FW:0]));
    endfunction

    function automatic logic [N-1:0] padd(input logic [N-1:0] a, input logic [N-1:0] b);
        logic sa, sb, sx, sy, stk;
        int ea, eb, ex, ey, d;
        logic [FW:0] ma, mb, mx, my;
        logic [EW-1:0] xx, yv, sum;
        logic [N-1:0] res;
        if (a == NAR || b == NAR) begin
            res = NAR;
        end else if (a == '0) begin
            res = b;
        end else if (b == '0) begin
            res = a;
        end else begin
            pdec(a, sa, ea, ma);
            pdec(b, sb, eb, mb);
            if (ea > eb || (ea == eb && ma >= mb)) begin
                sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
            end else begin
                sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
            end
            d  = ex - ey;
            xx = {1'b0, mx, 3'b000};
            yv = {1'b0, my, 3'b000};
            if (d >= EW) begin
                stk = 1'b1;
                yv  = '0;
            end else begin
                stk = |(yv & ~({EW{1'b1}} << d));
                yv  = yv >> d;
            end
            yv[0] = yv[0] | stk;
            sum   = (sx == sy) ? xx + yv : xx - yv;
            res   = (sum == '0) ? '0 : pnorm(sx, ex, WW'(sum), FW + 3, 1'b0);
        end
        return res;
    endfunction

    function automatic logic [N-1:0] pmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic sa, sb;
        int ea, eb;
        logic [FW:0] ma, mb;
        logic [N-1:0] res;
        if (a == NAR || b == NAR) begin
            res = NAR;
        end else if (a == '0 || b == '0) begin
            res = '0;
        end else begin
            pdec(a, sa, ea, ma);
            pdec(b, sb, eb, mb);
            res = pnorm(sa ^ sb, ea + eb, WW'(ma) * WW'(mb), 2 * FW, 1'b0);
        end
        return res;
    endfunction

    function automatic logic [N-1:0] pdiv(input logic [N-1:0] a, input logic [N-1:0] b);
        logic sa, sb;
        int ea, eb;
        logic [FW:0] ma, mb;
        logic [WW-1:0] num, q, rm;
        logic [N-1:0] res;
        if (a == NAR || b == NAR || b == '0) begin
            res = NAR;
        end else if (a == '0) begin
            res = '0;
        end else begin
            pdec(a, sa, ea, ma);
            pdec(b, sb, eb, mb);
            num = {ma, {(FW+3){1'b0}}};
            q   = num / WW'(mb);
            rm  = num % WW'(mb);
            res = pnorm(sa ^ sb, ea - eb, q, FW + 3, |rm);
        end
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q;
    logic [ID_W-1:0]   id_q;
    logic [4:0]        rdst_q;
    logic [N-1:0]      a_q, b_q, res_q, unit_out, mm_out, push_data;
    logic              resv_q, unit_start, unit_done, is_minmax, push, pop, match, reg_ok;
    logic [N-1:0]      mem_data [DEPTH];
    logic [ID_W-1:0]   mem_id   [DEPTH];
    logic [4:0]        mem_rd   [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW:0]       count_q;
    logic              unused_bits;

    assign unused_bits = ^{issue_req_instr[24:15], register_rs0, register_rs1};

    assign match = (issue_req_instr[6:0] == 7'b1111011) && (issue_req_instr[31:25] == 7'b0)
                   && (issue_req_instr[14:12] <= 3'b101);
    assign reg_ok = register_valid && (register_rs_valid == 2'b11) && (register_id == id_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:     if (issue_resp_accept) state_d = S_WAIT_REG;
            S_WAIT_REG: if (reg_ok) begin
                            state_d = S_EXEC;
                            cnt_d   = '0;
                        end
            S_EXEC: begin
                if (cnt_q != CW'(LATENCY)) cnt_d = cnt_q + 1'b1;
                else if (unit_done)        state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_ready    = 1'b0;
        register_ready = 1'b0;
        unit_start     = 1'b0;
        push           = 1'b0;
        case (state_q)
            S_IDLE:     issue_ready = !rst && (count_q < (PW+1)'(DEPTH));
            S_WAIT_REG: register_ready = 1'b1;
            S_EXEC: begin
                unit_start = 1'b1;
                push       = (cnt_q == CW'(LATENCY)) && unit_done;
            end
            default: ;
        endcase
        issue_resp_accept        = issue_valid && issue_ready && match;
        issue_resp_writeback     = issue_resp_accept;
        issue_resp_register_read = issue_resp_accept ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q   <= '0;
            id_q   <= '0;
            rdst_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            resv_q <= 1'b0;
        end else begin
            if (issue_resp_accept) begin
                f3_q   <= issue_req_instr[14:12];
                id_q   <= issue_req_id;
                rdst_q <= issue_req_instr[11:7];
            end
            if (register_ready && reg_ok) begin
                a_q <= register_rs0[N-1:0];
                b_q <= register_rs1[N-1:0];
            end
            if (unit_start) res_q <= unit_out;
            resv_q <= unit_start;
        end
    end

    // Arithmetic units take one registered stage; MIN/MAX finish without one.
    always_comb begin
        case (f3_q)
            3'b000:  unit_out = padd(a_q, b_q);
            3'b001:  unit_out = padd(a_q, -b_q);
            3'b010:  unit_out = pmul(a_q, b_q);
            3'b011:  unit_out = pdiv(a_q, b_q);
            default: unit_out = '0;
        endcase
    end

    assign is_minmax = (f3_q == 3'b100) || (f3_q == 3'b101);
    assign mm_out    = (($signed(a_q) < $signed(b_q)) ^ f3_q[0]) ? a_q : b_q;
    assign unit_done = is_minmax || resv_q;
    assign push_data = is_minmax ? mm_out : res_q;

    assign result_valid = (count_q != '0);
    assign pop          = result_valid && result_ready;
    assign result_data  = result_valid ? 32'(mem_data[rptr_q]) : 32'd0;
    assign result_id    = result_valid ? mem_id[rptr_q] : '0;
    assign result_rd    = result_valid ? mem_rd[rptr_q] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q] <= push_data;
            mem_id[wptr_q]   <= id_q;
            mem_rd[wptr_q]   <= rdst_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_cvxif_pau_q.sv
// Scoreboard bench for cvxif_pau_q: expected results queued at issue, checked as the core pops them.
module tb_cvxif_pau_q;

    localparam int N    = 16;
    localparam int LAT  = 3;
    localparam int DEP  = 2;
    localparam int ID_W = 4;
    localparam int SBW  = 32 + ID_W + 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [31:0]     issue_req_instr = '0;
    logic [ID_W-1:0] issue_req_id = '0;
    logic            issue_resp_accept;
    logic            issue_resp_writeback;
    logic [1:0]      issue_resp_register_read;
    logic            register_valid = 1'b0;
    logic            register_ready;
    logic [ID_W-1:0] register_id = '0;
    logic [31:0]     register_rs0 = '0;
    logic [31:0]     register_rs1 = '0;
    logic [1:0]      register_rs_valid = '0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [31:0]     result_data;
    logic [ID_W-1:0] result_id;
    logic [4:0]      result_rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_iss = 0;
    logic [SBW-1:0] sb[$];

    cvxif_pau_q #(.N(N), .ES(1), .LATENCY(LAT), .DEPTH(DEP), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_req_instr(issue_req_instr), .issue_req_id(issue_req_id),
        .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
        .issue_resp_register_read(issue_resp_register_read),
        .register_valid(register_valid), .register_ready(register_ready),
        .register_id(register_id), .register_rs0(register_rs0), .register_rs1(register_rs1),
        .register_rs_valid(register_rs_valid),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .result_id(result_id), .result_rd(result_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000000, 5'd2, 5'd1, f3, rd, 7'b1111011};
    endfunction

    always @(negedge clk) begin
        logic [SBW-1:0] e;
        if (!rst && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                chk("result_when_idle", 32'(result_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result_data", result_data, e[SBW-1 -: 32]);
                chk("result_id", 32'(result_id), 32'(e[ID_W+4:5]));
                chk("result_rd", 32'(result_rd), 32'(e[4:0]));
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [ID_W-1:0] id, input logic exp_acc);
        int n = 0;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_req_instr = instr;
        issue_req_id = id;
        #1;
        while (!issue_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("issue_timeout", 32'(issue_ready), 32'd1);
        t_iss = cyc;
        chk("accept", 32'(issue_resp_accept), 32'(exp_acc));
        chk("writeback", 32'(issue_resp_writeback), 32'(exp_acc));
        chk("reg_read", 32'(issue_resp_register_read), exp_acc ? 32'd3 : 32'd0);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic send_regs(input logic [ID_W-1:0] id, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        while (!register_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("reg_timeout", 32'(register_ready), 32'd1);
        register_valid = 1'b1;
        register_id = id;
        register_rs0 = {16'hA5A5, a};
        register_rs1 = {16'h5A5A, b};
        register_rs_valid = 2'b11;
        @(posedge clk);
        #1;
        register_valid = 1'b0;
        register_rs_valid = 2'b00;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [ID_W-1:0] id, input logic [4:0] rd,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv);
        issue(mk_instr(f3, rd), id, 1'b1);
        sb.push_back({16'h0000, expv, id, rd});
        send_regs(id, a, b);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("post_rst_result_valid", 32'(result_valid), 32'd0);
        chk("post_rst_result_data", result_data, 32'd0);
        chk("post_rst_register_ready", 32'(register_ready), 32'd0);
        @(posedge clk);
        #1 result_ready = 1'b1;

        // ADD with end-to-end latency measured from the issue cycle
        run_op(3'b000, 4'd3, 5'd5, 16'h4000, 16'h5000, 16'h5800);
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("add_latency", 32'(cyc - t_iss), 32'(LAT + 3));
        drain();

        run_op(3'b001, 4'd4, 5'd6, 16'h5000, 16'h4000, 16'h4000);
        run_op(3'b001, 4'd5, 5'd7, 16'h4000, 16'h5000, 16'hC000);
        run_op(3'b000, 4'd6, 5'd8, 16'h4000, 16'hC000, 16'h0000);
        run_op(3'b010, 4'd7, 5'd9, 16'h5000, 16'h5000, 16'h6000);
        run_op(3'b011, 4'd8, 5'd10, 16'h4000, 16'h5000, 16'h3000);
        run_op(3'b011, 4'd9, 5'd11, 16'h4000, 16'h0000, 16'h8000);
        run_op(3'b100, 4'd10, 5'd12, 16'h5000, 16'hB000, 16'hB000);
        run_op(3'b101, 4'd11, 5'd13, 16'h5000, 16'hB000, 16'h5000);
        run_op(3'b100, 4'd12, 5'd14, 16'h8000, 16'h4000, 16'h8000);
        drain();

        // rejected encodings leave the unit idle
        issue(mk_instr(3'b110, 5'd1), 4'd1, 1'b0);
        issue({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011}, 4'd1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("reject_no_register_ready", 32'(register_ready), 32'd0);
        end

        // operand transfer with a foreign id is ignored
        issue(mk_instr(3'b000, 5'd17), 4'd6, 1'b1);
        sb.push_back({16'h0000, 16'h5000, 4'd6, 5'd17});
        @(negedge clk);
        register_valid = 1'b1;
        register_id = 4'd7;
        register_rs0 = 32'h0000_6000;
        register_rs1 = 32'h0000_6000;
        register_rs_valid = 2'b11;
        @(posedge clk);
        #1 register_valid = 1'b0;
        @(negedge clk);
        chk("id_mismatch_still_waiting", 32'(register_ready), 32'd1);
        send_regs(4'd6, 16'h4000, 16'h4000);
        drain();

        // backpressure: fill the FIFO, then release in order
        @(posedge clk);
        #1 result_ready = 1'b0;
        run_op(3'b000, 4'd1, 5'd1, 16'h4000, 16'h5000, 16'h5800);
        run_op(3'b000, 4'd2, 5'd2, 16'h4000, 16'h4000, 16'h5000);
        repeat (LAT + 6) @(negedge clk);
        chk("full_issue_ready", 32'(issue_ready), 32'd0);
        chk("full_result_valid", 32'(result_valid), 32'd1);
        chk("full_head_id", 32'(result_id), 32'd1);
        repeat (3) @(negedge clk);
        chk("held_head_data", result_data, 32'h0000_5800);
        chk("held_head_id", 32'(result_id), 32'd1);
        @(posedge clk);
        #1 result_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("drained_issue_ready", 32'(issue_ready), 32'd1);

        // reset during EXEC with one buffered result
        @(posedge clk);
        #1 result_ready = 1'b0;
        run_op(3'b000, 4'd9, 5'd3, 16'h4000, 16'h4000, 16'h5000);
        repeat (LAT + 6) @(negedge clk);
        chk("buffered_before_rst", 32'(result_valid), 32'd1);
        run_op(3'b010, 4'd10, 5'd4, 16'h5000, 16'h5000, 16'h6000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_issue_ready", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("after_rst_result_valid", 32'(result_valid), 32'd0);
        chk("after_rst_result_data", result_data, 32'd0);
        chk("after_rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("after_rst_register_ready", 32'(register_ready), 32'd0);
        @(posedge clk);
        #1 result_ready = 1'b1;
        run_op(3'b000, 4'd11, 5'd21, 16'h5000, 16'h4000, 16'h5800);
        drain();
        repeat (LAT + 6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
